// File: rtl/ssd_pkg.sv
// Shared constants and the hex-to-seven-segment table for the SSD scanner.
package ssd_pkg;

    // All cathodes released (active-low), used whenever a digit is dark
    localparam logic [7:0] SEG_OFF = 8'hFF;

    // Bit positions inside the cathode byte {Ca,Cb,Cc,Cd,Ce,Cf,Cg,Dp}
    localparam int CATH_A_BIT  = 7;
    localparam int CATH_B_BIT  = 6;
    localparam int CATH_C_BIT  = 5;
    localparam int CATH_D_BIT  = 4;
    localparam int CATH_E_BIT  = 3;
    localparam int CATH_F_BIT  = 2;
    localparam int CATH_G_BIT  = 1;
    localparam int CATH_DP_BIT = 0;

    // Nibble to active-low abcdefg pattern
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'b0000001;
            4'h1: seg = 7'b1001111;
            4'h2: seg = 7'b0010010;
            4'h3: seg = 7'b0000110;
            4'h4: seg = 7'b1001100;
            4'h5: seg = 7'b0100100;
            4'h6: seg = 7'b0100000;
            4'h7: seg = 7'b0001111;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0000100;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b1100000;
            4'hC: seg = 7'b0110001;
            4'hD: seg = 7'b1000010;
            4'hE: seg = 7'b0110000;
            default: seg = 7'b0111000;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/ssd_hex_decoder.sv
// Combinational nibble to active-low abcdefg decoder.
module ssd_hex_decoder
    import ssd_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = hex_to_seg(nibble);

endmodule

// File: rtl/ssd_scan_ctrl.sv
// N-digit multiplexed seven-segment scanner with frame latching,
// leading-zero blanking, PWM brightness and dead time between digit slots.
module ssd_scan_ctrl
    import ssd_pkg::*;
#(
    parameter int N_DIGITS      = 8,
    parameter int SCAN_DIV_LOG2 = 18,
    parameter int BRIGHT_W      = 4,
    parameter int DEAD_CYC      = 64
) (
    input  logic                    ClkPort,
    input  logic                    Reset,
    input  logic [4*N_DIGITS-1:0]   value,
    input  logic [N_DIGITS-1:0]     dp_mask,
    input  logic [N_DIGITS-1:0]     digit_en,
    input  logic                    lz_blank,
    input  logic                    load,
    input  logic [BRIGHT_W-1:0]     brightness,
    output logic [N_DIGITS-1:0]     anodes,
    output logic [7:0]              cathodes,
    output logic                    frame_tick
);

    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);

    logic [SCAN_DIV_LOG2-1:0] presc;
    logic [IDX_W-1:0]         idx;
    logic                     presc_tc;
    logic                     wrap;

    logic [4*N_DIGITS-1:0]    shadow_value;
    logic [N_DIGITS-1:0]      shadow_dp;
    logic [N_DIGITS-1:0]      shadow_en;
    logic [4*N_DIGITS-1:0]    disp_value;
    logic [N_DIGITS-1:0]      disp_dp;
    logic [N_DIGITS-1:0]      disp_en;

    logic [N_DIGITS-1:0]      lz_mask;
    logic                     upper_zero;
    logic [3:0]               cur_nibble;
    logic                     cur_dp;
    logic                     cur_en;
    logic                     cur_lz;
    logic [6:0]               cur_seg;
    logic                     in_dead;
    logic                     bright_on;
    logic                     lit;

    assign presc_tc = &presc;
    assign wrap     = presc_tc && (idx == IDX_LAST);

    // Free-running prescaler; its terminal count steps the digit index, wrapping after the last digit
    always_ff @(posedge ClkPort or posedge Reset) begin
        if (Reset) begin
            presc <= '0;
            idx   <= '0;
        end else begin
            presc <= presc + 1'b1;
            if (presc_tc) begin
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end
        end
    end

    // Shadow captures on load; display takes the old shadow at the frame wrap so a frame never tears
    always_ff @(posedge ClkPort or posedge Reset) begin
        if (Reset) begin
            shadow_value <= '0;
            shadow_dp    <= '0;
            shadow_en    <= '0;
            disp_value   <= '0;
            disp_dp      <= '0;
            disp_en      <= '0;
            frame_tick   <= 1'b0;
        end else begin
            if (load) begin
                shadow_value <= value;
                shadow_dp    <= dp_mask;
                shadow_en    <= digit_en;
            end
            if (wrap) begin
                disp_value <= shadow_value;
                disp_dp    <= shadow_dp;
                disp_en    <= shadow_en;
            end
            frame_tick <= wrap;
        end
    end

    // A digit is a leading zero when it and every digit above it are zero; digit 0 is never blanked
    always_comb begin
        lz_mask    = '0;
        upper_zero = 1'b1;
        for (int k = N_DIGITS - 1; k >= 0; k--) begin
            upper_zero = upper_zero & (disp_value[4*k +: 4] == 4'h0);
            if (k != 0) begin
                lz_mask[k] = lz_blank & upper_zero;
            end
        end
    end

    // Select nibble, DP, enable and blank flag of the digit currently being scanned
    always_comb begin
        cur_nibble = '0;
        cur_dp     = 1'b0;
        cur_en     = 1'b0;
        cur_lz     = 1'b0;
        for (int k = 0; k < N_DIGITS; k++) begin
            if (idx == IDX_W'(k)) begin
                cur_nibble = disp_value[4*k +: 4];
                cur_dp     = disp_dp[k];
                cur_en     = disp_en[k];
                cur_lz     = lz_mask[k];
            end
        end
    end

    ssd_hex_decoder u_dec (
        .nibble (cur_nibble),
        .seg    (cur_seg)
    );

    assign in_dead   = presc < SCAN_DIV_LOG2'(DEAD_CYC);
    assign bright_on = (&brightness) || (presc[SCAN_DIV_LOG2-1 -: BRIGHT_W] < brightness);
    assign lit       = cur_en && !cur_lz && !in_dead && bright_on;

    // Registered drivers: light the selected digit or release everything
    always_ff @(posedge ClkPort or posedge Reset) begin
        if (Reset) begin
            anodes   <= '1;
            cathodes <= SEG_OFF;
        end else if (lit) begin
            anodes   <= ~(N_DIGITS'(1) << idx);
            cathodes <= {cur_seg, ~cur_dp};
        end else begin
            anodes   <= '1;
            cathodes <= SEG_OFF;
        end
    end

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Directed self-checking bench for ssd_scan_ctrl at 4 digits, 16 clocks per slot.
module tb_ssd_scan_ctrl;

    logic        ClkPort = 1'b0;
    logic        Reset;
    logic [15:0] value;
    logic [3:0]  dp_mask;
    logic [3:0]  digit_en;
    logic        lz_blank;
    logic        load;
    logic [3:0]  brightness;
    logic [3:0]  anodes;
    logic [7:0]  cathodes;
    logic        frame_tick;

    int checks = 0;
    int errors = 0;

    logic [3:0] an_s [64];
    logic [7:0] ca_s [64];
    logic       ft_s [64];

    // Expected cathode bytes {abcdefg, ~dp}
    localparam logic [7:0] C_0  = 8'h03;
    localparam logic [7:0] C_1  = 8'h9F;
    localparam logic [7:0] C_2  = 8'h25;
    localparam logic [7:0] C_2D = 8'h24;
    localparam logic [7:0] C_4  = 8'h99;
    localparam logic [7:0] C_5  = 8'h49;
    localparam logic [7:0] C_A  = 8'h11;
    localparam logic [7:0] C_F  = 8'h71;

    ssd_scan_ctrl #(
        .N_DIGITS      (4),
        .SCAN_DIV_LOG2 (4),
        .BRIGHT_W      (4),
        .DEAD_CYC      (1)
    ) dut (
        .ClkPort    (ClkPort),
        .Reset      (Reset),
        .value      (value),
        .dp_mask    (dp_mask),
        .digit_en   (digit_en),
        .lz_blank   (lz_blank),
        .load       (load),
        .brightness (brightness),
        .anodes     (anodes),
        .cathodes   (cathodes),
        .frame_tick (frame_tick)
    );

    // 100 MHz clock
    always #5 ClkPort = ~ClkPort;

    // Pulse load for one clock with new shadow contents
    task automatic do_load(input logic [15:0] v, input logic [3:0] dp, input logic [3:0] en);
        value    = v;
        dp_mask  = dp;
        digit_en = en;
        load     = 1'b1;
        @(negedge ClkPort);
        load     = 1'b0;
    endtask

    // Advance to the negedge right after the next frame_tick
    task automatic sync_frame();
        bit found;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge ClkPort);
            if (frame_tick === 1'b1) found = 1'b1;
        end
        checks++;
        if (found !== 1'b1) begin
            errors++;
            $display("[TB] FAIL sync_frame: frame_tick seen=%0b, required 1 within 200 clocks", found);
        end
    endtask

    // Record one full frame (64 clocks), sample j reflects scan state slot j/16, presc j%16
    task automatic capture_frame();
        for (int j = 0; j < 64; j++) begin
            @(negedge ClkPort);
            an_s[j] = anodes;
            ca_s[j] = cathodes;
            ft_s[j] = frame_tick;
        end
    endtask

    // Compare a captured frame against hand-derived digit patterns and the PWM/dead-time window
    task automatic check_frame(input string tag, input logic [31:0] cath,
                               input logic [3:0] en, input logic [3:0] br);
        int         ticks;
        int         s;
        int         p;
        bit         lit;
        logic [3:0] ea;
        logic [7:0] ec;
        ticks = 0;
        for (int j = 0; j < 64; j++) begin
            s   = j / 16;
            p   = j % 16;
            lit = en[s] && (p >= 1) && ((br == 4'hF) || (p < int'(br)));
            ea  = lit ? ~(4'b0001 << s) : 4'hF;
            ec  = lit ? cath[8*s +: 8] : 8'hFF;
            checks++;
            if (an_s[j] !== ea || ca_s[j] !== ec) begin
                errors++;
                $display("[TB] FAIL %s slot %0d presc %0d: anodes=%b cathodes=%h, required anodes=%b cathodes=%h",
                         tag, s, p, an_s[j], ca_s[j], ea, ec);
            end
            ticks += int'(ft_s[j]);
        end
        checks++;
        if (ticks !== 1 || ft_s[63] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL %s frame_tick: count=%0d last=%0b, required count=1 last=1",
                     tag, ticks, ft_s[63]);
        end
    endtask

    // Reset state, then a dark first frame with the wrap 64 clocks after release
    task automatic test_reset();
        int cnt;
        int lit_cnt;
        Reset = 1'b1;
        repeat (3) @(negedge ClkPort);
        checks++;
        if (anodes !== 4'hF || cathodes !== 8'hFF || frame_tick !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_state: anodes=%b cathodes=%h tick=%b, required 1111 ff 0",
                     anodes, cathodes, frame_tick);
        end
        Reset   = 1'b0;
        cnt     = 0;
        lit_cnt = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge ClkPort);
            cnt++;
            if (anodes !== 4'hF || cathodes !== 8'hFF) lit_cnt++;
            if (frame_tick === 1'b1) break;
        end
        checks++;
        if (cnt !== 64) begin
            errors++;
            $display("[TB] FAIL reset_first_wrap: clocks=%0d, required 64", cnt);
        end
        checks++;
        if (lit_cnt !== 0) begin
            errors++;
            $display("[TB] FAIL reset_dark_frame: lit samples=%0d, required 0", lit_cnt);
        end
    endtask

    // Plain scan of 12AF at full brightness
    task automatic test_basic();
        do_load(16'h12AF, 4'b0000, 4'hF);
        sync_frame();
        capture_frame();
        check_frame("basic_12AF", {C_1, C_2, C_A, C_F}, 4'hF, 4'hF);
    endtask

    // Leading-zero blanking on and off
    task automatic test_lz_blank();
        lz_blank = 1'b1;
        do_load(16'h0040, 4'b0000, 4'hF);
        sync_frame();
        capture_frame();
        check_frame("lz_0040", {C_0, C_0, C_4, C_0}, 4'b0011, 4'hF);
        do_load(16'h0000, 4'b0000, 4'hF);
        sync_frame();
        capture_frame();
        check_frame("lz_0000", {C_0, C_0, C_0, C_0}, 4'b0001, 4'hF);
        lz_blank = 1'b0;
        do_load(16'h0040, 4'b0000, 4'hF);
        sync_frame();
        capture_frame();
        check_frame("nolz_0040", {C_0, C_0, C_4, C_0}, 4'hF, 4'hF);
    endtask

    // PWM duty: half brightness lights presc 1..7, zero never lights
    task automatic test_brightness();
        do_load(16'h12AF, 4'b0000, 4'hF);
        brightness = 4'h8;
        sync_frame();
        capture_frame();
        check_frame("bright_8", {C_1, C_2, C_A, C_F}, 4'hF, 4'h8);
        brightness = 4'h0;
        capture_frame();
        check_frame("bright_0", {C_1, C_2, C_A, C_F}, 4'hF, 4'h0);
        brightness = 4'hF;
    endtask

    // Load landing on the wrap edge: current frame keeps old data, new data the frame after
    task automatic test_back_to_back();
        do_load(16'h5555, 4'b0000, 4'hF);
        sync_frame();
        repeat (63) @(negedge ClkPort);
        value = 16'hAAAA;
        load  = 1'b1;
        @(negedge ClkPort);
        load  = 1'b0;
        checks++;
        if (frame_tick !== 1'b1) begin
            errors++;
            $display("[TB] FAIL b2b_wrap_alignment: frame_tick=%b, required 1", frame_tick);
        end
        capture_frame();
        check_frame("b2b_old_5555", {C_5, C_5, C_5, C_5}, 4'hF, 4'hF);
        capture_frame();
        check_frame("b2b_new_AAAA", {C_A, C_A, C_A, C_A}, 4'hF, 4'hF);
    endtask

    // Decimal point and disabled digit, then an asynchronous reset in the middle of a lit slot
    task automatic test_dp_en_reset();
        int cnt;
        do_load(16'h12AF, 4'b0100, 4'b1101);
        sync_frame();
        capture_frame();
        check_frame("dp_en", {C_1, C_2D, C_A, C_F}, 4'b1101, 4'hF);
        repeat (3) @(negedge ClkPort);
        checks++;
        if (anodes !== 4'b1110 || cathodes !== C_F) begin
            errors++;
            $display("[TB] FAIL pre_reset_lit: anodes=%b cathodes=%h, required 1110 %h",
                     anodes, cathodes, C_F);
        end
        #1 Reset = 1'b1;
        #1;
        checks++;
        if (anodes !== 4'hF || cathodes !== 8'hFF || frame_tick !== 1'b0) begin
            errors++;
            $display("[TB] FAIL async_reset_dark: anodes=%b cathodes=%h tick=%b, required 1111 ff 0",
                     anodes, cathodes, frame_tick);
        end
        @(negedge ClkPort);
        Reset    = 1'b0;
        value    = 16'h12AF;
        dp_mask  = 4'b0100;
        digit_en = 4'b1101;
        load     = 1'b1;
        cnt      = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge ClkPort);
            load = 1'b0;
            cnt++;
            if (frame_tick === 1'b1) break;
        end
        checks++;
        if (cnt !== 64) begin
            errors++;
            $display("[TB] FAIL reset_restart_wrap: clocks=%0d, required 64", cnt);
        end
        capture_frame();
        check_frame("after_reset", {C_1, C_2D, C_A, C_F}, 4'b1101, 4'hF);
    endtask

    // Run all scenarios in order and report
    initial begin
        Reset      = 1'b1;
        value      = '0;
        dp_mask    = '0;
        digit_en   = '0;
        lz_blank   = 1'b0;
        load       = 1'b0;
        brightness = 4'hF;
        test_reset();
        test_basic();
        test_lz_blank();
        test_brightness();
        test_back_to_back();
        test_dp_en_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
